core_fetch_port: RTL and testbench



---
 rtl/core_fetch_port.sv | 195 +++++++++++++++++++
 tb/tb_core_fetch_port.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/core_fetch_port.sv
// core_fetch_port: responder end of the instruction-fetch handshake.
// Turns each fetch request into a single read on a pipelined memory bus
// with waitrequest/readdatavalid semantics. A one-entry last-word buffer
// answers repeated fetches of the same word without a bus cycle. A bus
// timeout completes the request with a fault word so the core never hangs.
`timescale 1ns/1ps
module core_fetch_port #(
    parameter int unsigned HIT_BUFFER     = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter logic [31:0] FAULT_WORD     = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fetch,
    input  logic [29:0] addr,
    input  logic        invalidate,
    output logic        fetched,
    output logic [31:0] fetch_data,
    output logic        bus_error,
    output logic        mem_read,
    output logic [29:0] mem_address,
    input  logic        mem_waitrequest,
    input  logic        mem_readdatavalid,
    input  logic [31:0] mem_readdata
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ISSUE   = 2'd1;
    localparam logic [1:0] ST_WAIT    = 2'd2;
    localparam logic [1:0] ST_RESPOND = 2'd3;

    // 8-bit wait counter; the limit is the number of ISSUE/WAIT cycles allowed.
    localparam logic [7:0] TMO_LIMIT = 8'(TIMEOUT_CYCLES);

    logic [1:0]  state_q,       state_d;
    logic [29:0] req_addr_q,    req_addr_d;
    logic        mem_read_q,    mem_read_d;
    logic [29:0] mem_address_q, mem_address_d;
    logic        fetched_q,     fetched_d;
    logic [31:0] fetch_data_q,  fetch_data_d;
    logic        bus_error_q,   bus_error_d;
    logic [7:0]  tmo_cnt_q,     tmo_cnt_d;
    logic        suppress_q,    suppress_d;
    logic        buf_valid_q,   buf_valid_d;
    logic [29:0] buf_addr_q,    buf_addr_d;
    logic [31:0] buf_data_q,    buf_data_d;

    logic        buf_hit;
    logic        tmo_expire;
    logic        fill_req;

    // A hit needs the buffer enabled, valid, matching, and no invalidate racing the sample.
    assign buf_hit = (HIT_BUFFER != 0) && buf_valid_q && (addr == buf_addr_q) && !invalidate;

    // The counter value after this cycle's increment reaching the limit ends the wait.
    assign tmo_expire = ((tmo_cnt_q + 8'd1) == TMO_LIMIT);

    // Next-state logic for the handshake FSM, bus side and last-word buffer.
    always_comb begin
        state_d       = state_q;
        req_addr_d    = req_addr_q;
        mem_read_d    = mem_read_q;
        mem_address_d = mem_address_q;
        fetched_d     = 1'b0;
        fetch_data_d  = fetch_data_q;
        bus_error_d   = 1'b0;
        tmo_cnt_d     = tmo_cnt_q;
        suppress_d    = suppress_q;
        buf_valid_d   = buf_valid_q;
        buf_addr_d    = buf_addr_q;
        buf_data_d    = buf_data_q;
        fill_req      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                suppress_d = 1'b0;
                tmo_cnt_d  = 8'd0;
                if (fetch) begin
                    req_addr_d = addr;
                    if (buf_hit) begin
                        state_d      = ST_RESPOND;
                        fetched_d    = 1'b1;
                        fetch_data_d = buf_data_q;
                    end else begin
                        state_d       = ST_ISSUE;
                        mem_read_d    = 1'b1;
                        mem_address_d = addr;
                    end
                end
            end

            ST_ISSUE: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (invalidate) begin
                    suppress_d = 1'b1;
                end
                if (!mem_waitrequest) begin
                    mem_read_d = 1'b0;
                    if (mem_readdatavalid) begin
                        // Zero-latency slave: data arrives with the accept.
                        state_d      = ST_RESPOND;
                        fetched_d    = 1'b1;
                        fetch_data_d = mem_readdata;
                        fill_req     = 1'b1;
                    end else if (tmo_expire) begin
                        state_d      = ST_RESPOND;
                        fetched_d    = 1'b1;
                        bus_error_d  = 1'b1;
                        fetch_data_d = FAULT_WORD;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end else if (tmo_expire) begin
                    mem_read_d   = 1'b0;
                    state_d      = ST_RESPOND;
                    fetched_d    = 1'b1;
                    bus_error_d  = 1'b1;
                    fetch_data_d = FAULT_WORD;
                end
            end

            ST_WAIT: begin
                tmo_cnt_d = tmo_cnt_q + 8'd1;
                if (invalidate) begin
                    suppress_d = 1'b1;
                end
                if (mem_readdatavalid) begin
                    state_d      = ST_RESPOND;
                    fetched_d    = 1'b1;
                    fetch_data_d = mem_readdata;
                    fill_req     = 1'b1;
                end else if (tmo_expire) begin
                    state_d      = ST_RESPOND;
                    fetched_d    = 1'b1;
                    bus_error_d  = 1'b1;
                    fetch_data_d = FAULT_WORD;
                end
            end

            default: begin
                // RESPOND: fetch here belongs to the completing request, so ignore it.
                state_d = ST_IDLE;
            end
        endcase

        // An invalidate seen anywhere during the transaction blocks the fill.
        if (fill_req && (HIT_BUFFER != 0) && !suppress_q && !invalidate) begin
            buf_valid_d = 1'b1;
            buf_addr_d  = req_addr_q;
            buf_data_d  = mem_readdata;
        end

        if (invalidate) begin
            buf_valid_d = 1'b0;
        end
    end

    // State and output registers; reset also empties the buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_addr_q    <= '0;
            mem_read_q    <= 1'b0;
            mem_address_q <= '0;
            fetched_q     <= 1'b0;
            fetch_data_q  <= '0;
            bus_error_q   <= 1'b0;
            tmo_cnt_q     <= '0;
            suppress_q    <= 1'b0;
            buf_valid_q   <= 1'b0;
            buf_addr_q    <= '0;
            buf_data_q    <= '0;
        end else begin
            state_q       <= state_d;
            req_addr_q    <= req_addr_d;
            mem_read_q    <= mem_read_d;
            mem_address_q <= mem_address_d;
            fetched_q     <= fetched_d;
            fetch_data_q  <= fetch_data_d;
            bus_error_q   <= bus_error_d;
            tmo_cnt_q     <= tmo_cnt_d;
            suppress_q    <= suppress_d;
            buf_valid_q   <= buf_valid_d;
            buf_addr_q    <= buf_addr_d;
            buf_data_q    <= buf_data_d;
        end
    end

    assign fetched     = fetched_q;
    assign fetch_data  = fetch_data_q;
    assign bus_error   = bus_error_q;
    assign mem_read    = mem_read_q;
    assign mem_address = mem_address_q;

endmodule

// File: tb/tb_core_fetch_port.sv
// Directed testbench for core_fetch_port: miss, hit, stall, invalidate race,
// address flush, timeout with late data, and reset mid-transaction.
`timescale 1ns/1ps
module tb_core_fetch_port;

    localparam logic [31:0] FAULT = 32'hDEAD_BEEF;

    logic        clk;
    logic        rst;
    logic        fetch;
    logic [29:0] addr;
    logic        invalidate;
    logic        fetched;
    logic [31:0] fetch_data;
    logic        bus_error;
    logic        mem_read;
    logic [29:0] mem_address;
    logic        mem_waitrequest;
    logic        mem_readdatavalid;
    logic [31:0] mem_readdata;

    int total = 0;
    int bad   = 0;

    core_fetch_port #(
        .HIT_BUFFER    (1),
        .TIMEOUT_CYCLES(8),
        .FAULT_WORD    (FAULT)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .fetch            (fetch),
        .addr             (addr),
        .invalidate       (invalidate),
        .fetched          (fetched),
        .fetch_data       (fetch_data),
        .bus_error        (bus_error),
        .mem_read         (mem_read),
        .mem_address      (mem_address),
        .mem_waitrequest  (mem_waitrequest),
        .mem_readdatavalid(mem_readdatavalid),
        .mem_readdata     (mem_readdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just past the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; fetch = 1'b0; addr = '0; invalidate = 1'b0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        tick(); tick();
        chk("rst_fetched", {31'd0, fetched}, 32'd0);
        chk("rst_mem_read", {31'd0, mem_read}, 32'd0);
        chk("rst_mem_address", {2'd0, mem_address}, 32'd0);
        chk("rst_fetch_data", fetch_data, 32'd0);
        chk("rst_bus_error", {31'd0, bus_error}, 32'd0);
        rst = 1'b0;
        tick();

        // Miss, zero-wait slave, data two cycles after the read.
        fetch = 1'b1; addr = 30'h10;
        tick();
        chk("miss_read", {31'd0, mem_read}, 32'd1);
        chk("miss_addr", {2'd0, mem_address}, 32'h10);
        chk("miss_nofetched", {31'd0, fetched}, 32'd0);
        tick();
        chk("miss_read_drop", {31'd0, mem_read}, 32'd0);
        tick();
        chk("miss_wait", {31'd0, fetched}, 32'd0);
        mem_readdatavalid = 1'b1; mem_readdata = 32'h1234_5678;
        tick();
        chk("miss_fetched", {31'd0, fetched}, 32'd1);
        chk("miss_data", fetch_data, 32'h1234_5678);
        chk("miss_buserr", {31'd0, bus_error}, 32'd0);
        mem_readdatavalid = 1'b0; mem_readdata = '0; fetch = 1'b0;
        tick();
        chk("miss_once", {31'd0, fetched}, 32'd0);

        // Hit on the same word.
        fetch = 1'b1; addr = 30'h10;
        tick();
        chk("hit_fetched", {31'd0, fetched}, 32'd1);
        chk("hit_data", fetch_data, 32'h1234_5678);
        chk("hit_noread", {31'd0, mem_read}, 32'd0);
        fetch = 1'b0;
        tick();
        chk("hit_once", {31'd0, fetched}, 32'd0);
        chk("hit_noread2", {31'd0, mem_read}, 32'd0);

        // Waitrequest stall for three cycles.
        mem_waitrequest = 1'b1; fetch = 1'b1; addr = 30'h20;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk($sformatf("stall_read%0d", i), {31'd0, mem_read}, 32'd1);
            chk($sformatf("stall_addr%0d", i), {2'd0, mem_address}, 32'h20);
        end
        mem_waitrequest = 1'b0;
        tick();
        chk("stall_drop", {31'd0, mem_read}, 32'd0);
        mem_readdatavalid = 1'b1; mem_readdata = 32'hCAFE_F00D;
        tick();
        chk("stall_fetched", {31'd0, fetched}, 32'd1);
        chk("stall_data", fetch_data, 32'hCAFE_F00D);
        mem_readdatavalid = 1'b0; fetch = 1'b0;
        tick();
        chk("stall_once", {31'd0, fetched}, 32'd0);

        // Invalidate during WAIT suppresses the fill.
        fetch = 1'b1; addr = 30'h30;
        tick(); tick();
        invalidate = 1'b1;
        tick();
        invalidate = 1'b0;
        mem_readdatavalid = 1'b1; mem_readdata = 32'h3030_3030;
        tick();
        chk("inv_fetched", {31'd0, fetched}, 32'd1);
        chk("inv_data", fetch_data, 32'h3030_3030);
        mem_readdatavalid = 1'b0; fetch = 1'b0;
        tick();
        fetch = 1'b1; addr = 30'h30;
        tick();
        chk("inv_refetch_read", {31'd0, mem_read}, 32'd1);
        chk("inv_refetch_nohit", {31'd0, fetched}, 32'd0);
        tick();
        mem_readdatavalid = 1'b1; mem_readdata = 32'h3131_3131;
        tick();
        chk("inv_refetch_data", fetch_data, 32'h3131_3131);
        mem_readdatavalid = 1'b0; fetch = 1'b0;
        tick();

        // Invalidate coincident with the IDLE sample forces a miss.
        fetch = 1'b1; addr = 30'h30; invalidate = 1'b1;
        tick();
        chk("invsample_read", {31'd0, mem_read}, 32'd1);
        chk("invsample_nohit", {31'd0, fetched}, 32'd0);
        invalidate = 1'b0;
        tick();
        mem_readdatavalid = 1'b1; mem_readdata = 32'h3232_3232;
        tick();
        chk("invsample_data", fetch_data, 32'h3232_3232);
        mem_readdatavalid = 1'b0; fetch = 1'b0;
        tick();

        // Address flush mid-WAIT: old data returned, then new request.
        fetch = 1'b1; addr = 30'h40;
        tick(); tick();
        addr = 30'h80;
        tick();
        mem_readdatavalid = 1'b1; mem_readdata = 32'h4040_4040;
        tick();
        chk("flush_fetched", {31'd0, fetched}, 32'd1);
        chk("flush_olddata", fetch_data, 32'h4040_4040);
        mem_readdatavalid = 1'b0;
        tick();
        chk("flush_respond_idle", {31'd0, fetched}, 32'd0);
        chk("flush_no_read_yet", {31'd0, mem_read}, 32'd0);
        tick();
        chk("flush_new_read", {31'd0, mem_read}, 32'd1);
        chk("flush_new_addr", {2'd0, mem_address}, 32'h80);
        tick();
        mem_readdatavalid = 1'b1; mem_readdata = 32'h8080_8080;
        tick();
        chk("flush_new_data", fetch_data, 32'h8080_8080);
        mem_readdatavalid = 1'b0; fetch = 1'b0;
        tick();

        // Timeout after eight cycles with a silent slave.
        fetch = 1'b1; addr = 30'h50;
        tick();
        chk("tmo_read", {31'd0, mem_read}, 32'd1);
        for (int i = 1; i < 8; i++) begin
            tick();
            chk($sformatf("tmo_wait%0d", i), {31'd0, fetched}, 32'd0);
        end
        tick();
        chk("tmo_fetched", {31'd0, fetched}, 32'd1);
        chk("tmo_buserr", {31'd0, bus_error}, 32'd1);
        chk("tmo_data", fetch_data, FAULT);
        chk("tmo_read_low", {31'd0, mem_read}, 32'd0);
        fetch = 1'b0; mem_readdatavalid = 1'b1; mem_readdata = 32'h5555_5555;
        tick();
        chk("tmo_late1", {31'd0, fetched}, 32'd0);
        chk("tmo_buserr_once", {31'd0, bus_error}, 32'd0);
        tick();
        chk("tmo_late2", {31'd0, fetched}, 32'd0);
        mem_readdatavalid = 1'b0;

        // The timed-out word was not buffered.
        fetch = 1'b1; addr = 30'h50;
        tick();
        chk("tmo_nofill", {31'd0, mem_read}, 32'd1);

        // Reset mid-ISSUE.
        rst = 1'b1; fetch = 1'b0;
        tick();
        chk("rstmid_read", {31'd0, mem_read}, 32'd0);
        chk("rstmid_fetched", {31'd0, fetched}, 32'd0);
        rst = 1'b0;
        tick();
        fetch = 1'b1; addr = 30'h80;
        tick();
        chk("rstmid_bufclear", {31'd0, mem_read}, 32'd1);
        chk("rstmid_nohit", {31'd0, fetched}, 32'd0);
        fetch = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
